// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM burst arbiter.
// State encoding and master indices are used by both the arbiter and its round-robin picker.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_BUSY = 2'd1,
        ST_WR_BUSY = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/sdram_burst_arbiter_rr_arb2.sv
// Two-request round-robin picker. This block is purely combinational.
// The priority pointer is held in a register in the parent module.
import sdram_arb_pkg::*;

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        if (req[M0] && req[M1]) begin
            winner = rr_ptr;
        end else if (req[M1]) begin
            winner = M1;
        end else begin
            winner = M0;
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Grants the single sdram_core burst port to one of two client masters, one burst at a time.
// Masters take turns in round-robin order, and within a master a write wins over a read.
import sdram_arb_pkg::*;

module sdram_burst_arbiter #(
    parameter int MEM_DATA_BITS = 16,
    parameter int ADDR_BITS     = 24,
    parameter int BURST_BITS    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [1:0]                 m_rd_burst_req,
    input  logic [2*BURST_BITS-1:0]    m_rd_burst_len,
    input  logic [2*ADDR_BITS-1:0]     m_rd_burst_addr,
    output logic [1:0]                 m_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]   m_rd_burst_data,
    output logic [1:0]                 m_rd_burst_finish,

    input  logic [1:0]                 m_wr_burst_req,
    input  logic [2*BURST_BITS-1:0]    m_wr_burst_len,
    input  logic [2*ADDR_BITS-1:0]     m_wr_burst_addr,
    output logic [1:0]                 m_wr_burst_data_req,
    input  logic [2*MEM_DATA_BITS-1:0] m_wr_burst_data,
    output logic [1:0]                 m_wr_burst_finish,

    output logic                       rd_burst_req,
    output logic [BURST_BITS-1:0]      rd_burst_len,
    output logic [ADDR_BITS-1:0]       rd_burst_addr,
    input  logic                       rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0]   rd_burst_data,
    input  logic                       rd_burst_finish,

    output logic                       wr_burst_req,
    output logic [BURST_BITS-1:0]      wr_burst_len,
    output logic [ADDR_BITS-1:0]       wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]   wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,

    output logic                       grant_id,
    output logic                       busy
);

    state_t                 state;
    logic                   rr_ptr;
    logic [1:0]             cand;
    logic                   any_req;
    logic                   winner;
    logic [BURST_BITS-1:0]  sel_rd_len, sel_wr_len;
    logic [ADDR_BITS-1:0]   sel_rd_addr, sel_wr_addr;

    assign cand = m_rd_burst_req | m_wr_burst_req;

    rr_arb2 u_rr_arb2 (
        .req    (cand),
        .rr_ptr (rr_ptr),
        .valid  (any_req),
        .winner (winner)
    );

    assign sel_rd_len  = winner ? m_rd_burst_len[2*BURST_BITS-1:BURST_BITS] : m_rd_burst_len[BURST_BITS-1:0];
    assign sel_wr_len  = winner ? m_wr_burst_len[2*BURST_BITS-1:BURST_BITS] : m_wr_burst_len[BURST_BITS-1:0];
    assign sel_rd_addr = winner ? m_rd_burst_addr[2*ADDR_BITS-1:ADDR_BITS]  : m_rd_burst_addr[ADDR_BITS-1:0];
    assign sel_wr_addr = winner ? m_wr_burst_addr[2*ADDR_BITS-1:ADDR_BITS]  : m_wr_burst_addr[ADDR_BITS-1:0];

    // NOTE: the reset is sampled inside the clocked block, so it is synchronous.
    // Every register is cleared here, and all state updates use <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= M0;
            grant_id      <= M0;
            busy          <= 1'b0;
            rd_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            rd_burst_addr <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        busy     <= 1'b1;
                        if (m_wr_burst_req[winner]) begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_len  <= sel_wr_len;
                            wr_burst_addr <= sel_wr_addr;
                            state         <= ST_WR_BUSY;
                        end else begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_len  <= sel_rd_len;
                            rd_burst_addr <= sel_rd_addr;
                            state         <= ST_RD_BUSY;
                        end
                    end
                end
                ST_RD_BUSY: begin
                    if (rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        busy         <= 1'b0;
                        rr_ptr       <= ~grant_id;
                        state        <= ST_GAP;
                    end
                end
                ST_WR_BUSY: begin
                    if (wr_burst_finish) begin
                        wr_burst_req <= 1'b0;
                        busy         <= 1'b0;
                        rr_ptr       <= ~grant_id;
                        state        <= ST_GAP;
                    end
                end
                // The GAP cycle stops a request that is still high in the finish cycle from being granted again.
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Core responses are routed only while a burst of the matching type is in progress.
    // As a result, a stray finish or a mistyped finish never reaches a client.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment, so no latches are inferred.
        m_rd_burst_data_valid = '0;
        m_rd_burst_finish     = '0;
        m_wr_burst_data_req   = '0;
        m_wr_burst_finish     = '0;
        wr_burst_data         = '0;
        m_rd_burst_data       = rd_burst_data;
        if (state == ST_RD_BUSY) begin
            m_rd_burst_data_valid[grant_id] = rd_burst_data_valid;
            m_rd_burst_finish[grant_id]     = rd_burst_finish;
        end
        if (state == ST_WR_BUSY) begin
            m_wr_burst_data_req[grant_id] = wr_burst_data_req;
            m_wr_burst_finish[grant_id]   = wr_burst_finish;
            wr_burst_data = grant_id ? m_wr_burst_data[2*MEM_DATA_BITS-1:MEM_DATA_BITS]
                                     : m_wr_burst_data[MEM_DATA_BITS-1:0];
        end
    end

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Shares the single burst interface of sdram_core between two client masters. Typical clients: a capture/DMA writer and a readback or test engine.
- Each master has its own read and write burst channels, with the same signalling as the sdram_core user side. The block grants one burst at a time, using round-robin between masters.
- It sits between the clients and sdram_core, in the sdram_clk domain.

Parameters:
- MEM_DATA_BITS, 16, user data width.
- ADDR_BITS, 24, burst base address width.
- BURST_BITS, 10, burst length width (words, not bytes).

Ports:
- clk  in  1  sdram controller clock (sdram_clk).
- rst_n  in  1  reset, synchronous, active-low.
- m_rd_burst_req  in  2  per-master read request. Bit i = master i. Held high until that master's finish.
- m_rd_burst_len  in  2*BURST_BITS  per-master read length. Slice i = master i.
- m_rd_burst_addr  in  2*ADDR_BITS  per-master read base address.
- m_rd_burst_data_valid  out  2  read data valid, routed to the granted master only.
- m_rd_burst_data  out  MEM_DATA_BITS  read data, broadcast to both masters.
- m_rd_burst_finish  out  2  read finish pulse, routed to the granted master.
- m_wr_burst_req  in  2  per-master write request. Held high until that master's finish.
- m_wr_burst_len  in  2*BURST_BITS  per-master write length.
- m_wr_burst_addr  in  2*ADDR_BITS  per-master write base address.
- m_wr_burst_data_req  out  2  write data request, routed to the granted master.
- m_wr_burst_data  in  2*MEM_DATA_BITS  per-master write data.
- m_wr_burst_finish  out  2  write finish pulse, routed to the granted master.
- rd_burst_req, rd_burst_len, rd_burst_addr  out  1/BURST_BITS/ADDR_BITS  to sdram_core.
- rd_burst_data_valid, rd_burst_data, rd_burst_finish  in  1/MEM_DATA_BITS/1  from sdram_core.
- wr_burst_req, wr_burst_len, wr_burst_addr  out  1/BURST_BITS/ADDR_BITS  to sdram_core.
- wr_burst_data  out  MEM_DATA_BITS  to sdram_core.
- wr_burst_data_req, wr_burst_finish  in  1/1  from sdram_core.
- grant_id  out  1  master owning the current or last burst.
- busy  out  1  high while a burst is outstanding.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State = IDLE.
  - All req, valid, data_req and finish outputs = 0. len, addr and wr data outputs = 0.
  - grant_id = 0, busy = 0, rr_ptr = 0 (master 0 has priority first).
  - Reset mid-burst abandons the burst immediately. sdram_core is reset by the same source.
- States: IDLE, RD_BUSY, WR_BUSY, GAP.
- IDLE:
  - Evaluate requests. Master i is a candidate if m_rd_burst_req[i] or m_wr_burst_req[i] is high.
  - Round-robin: the candidate equal to rr_ptr wins; otherwise the other candidate wins.
  - Within the winning master, write has priority over read.
  - On the next edge:
    - Register grant_id and the selected len/addr into the output registers.
    - Assert rd_burst_req or wr_burst_req.
    - Set busy = 1 and enter RD_BUSY or WR_BUSY.
  - Latency: client req sampled high at edge N gives the core req high after edge N.
- RD_BUSY / WR_BUSY:
  - Core req, len and addr are held constant until the matching finish. Client inputs are ignored during this time.
  - Routing (combinational on grant_id):
    - rd_burst_data_valid, wr_burst_data_req and the finish pulses go to bit grant_id.
    - The other bit is 0.
    - wr_burst_data = slice grant_id of m_wr_burst_data.
  - On the core finish pulse (edge F):
    - Deassert core req and set busy = 0.
    - Set rr_ptr = ~grant_id.
    - Go to GAP.
    - The finish pulse is passed through to the client in the same cycle, so the client drops its req at F+1.
- GAP:
  - One cycle. No arbitration, so a req still high in the finish cycle is not re-granted.
  - Then go to IDLE.
  - Minimum spacing: two idle cycles on the core req between bursts.
- Boundary conditions:
  - Client drops req mid-burst: the burst runs to finish. There is no abort.
  - Finish of the other type, or a finish in IDLE or GAP: ignored; no client finish is emitted.
  - len = 0: passed through unchanged; legality is the core's concern.
  - Both masters requesting continuously: grants alternate 0,1,0,1.
  - Same master with rd and wr both pending: wr is granted, then rd on that master's next grant.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding constants: ST_IDLE, ST_RD_BUSY, ST_WR_BUSY, ST_GAP;
  - master index constants: M0 = 0, M1 = 1.
- Sub-module rr_arb2: two-request round-robin pick, given the request vector and rr_ptr. Combinational, with the pointer registered in the parent.

Test Plan:
- Reset check: hold rst_n = 0 for 3 clk with all reqs high → all outputs 0. After release, master 0 is granted first (core req high at the second edge).
- Single master 0 write: len = 128, addr = 0x000100.
  - Core sees wr_burst_addr = 0x000100 and len = 128.
  - All 128 wr_data_req pulses are routed to bit 0; data comes from slice 0.
  - m_wr_burst_finish = 2'b01.
  - busy falls at finish.
- Contention, both masters requesting reads continuously (m0 addr 0x0, m1 addr 0x800000) → grant_id sequence 0,1,0,1. rd_burst_data_valid never appears on the non-granted bit.
- Same master rd+wr: master 1 rd and wr raised together → write burst first, then read. rr_ptr still alternates if master 0 is also requesting.
- Reset mid-burst: rst_n low at word 40 of a 128-word read → req and valid outputs 0 on the next edge, state IDLE, no client finish emitted.
- Stray finish: pulse wr_burst_finish while in IDLE → no m_wr_burst_finish, state unchanged.
